// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle MIPS ALU with start/busy/done handshake
//
// Single-cycle ops (ADD/SUB/BEQ/SLL/AND/OR/NOR/SLT, DIV by zero) complete on
// the accepting edge; MUL (shift-add) and DIV (restoring) take W cycles.
//
// Ports:
//   clk     in  1  rising-edge clock
//   rst_n   in  1  asynchronous active-low reset
//   start   in  1  launch operation, sampled only while busy = 0
//   op      in  4  operation code
//   in1     in  W  Rs operand
//   in2     in  W  Rt / immediate operand
//   busy    out 1  iterative operation in progress
//   done    out 1  one-cycle pulse, result valid
//   out     out W  result / low product / quotient
//   out_hi  out W  high product / remainder, 0 for single-cycle ops
//   zero    out 1  out == 0 for the completed operation
//   div0    out 1  last completed op was DIV with in2 == 0
module alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic [W-1:0] out_hi,
  output logic         zero,
  output logic         div0
);

  localparam int SHW = $clog2(W);

  localparam logic [3:0] OP_AND = 4'b0000 | 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1101;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           is_mul_q, is_mul_d;
  logic [W-1:0]   a_q, a_d;        // multiplicand or divisor
  logic [W-1:0]   hi_q, hi_d;      // partial product high / partial remainder
  logic [W-1:0]   lo_q, lo_d;      // multiplier shifting out / quotient shifting in
  logic [W-1:0]   out_q, out_d;
  logic [W-1:0]   out_hi_q, out_hi_d;
  logic           zero_q, zero_d;
  logic           div0_q, div0_d;
  logic           done_q, done_d;

  logic [W-1:0]   sc_out, sc_hi;
  logic           sc_div0;
  logic [W-1:0]   it_hi, it_lo;
  logic [W:0]     mul_sum, div_sh;
  logic           div_ge;

  // Single-cycle result from the live inputs; only used on an accepting edge.
  always_comb begin
    sc_out  = '0;
    sc_hi   = '0;
    sc_div0 = 1'b0;
    case (op)
      OP_ADD:        sc_out = in1 + in2;
      OP_SUB,
      OP_BEQ:        sc_out = in1 - in2;
      OP_SLL:        sc_out = in1 << in2[SHW-1:0];
      OP_AND:        sc_out = in1 & in2;
      OP_OR:         sc_out = in1 | in2;
      OP_NOR:        sc_out = ~(in1 | in2);
      OP_SLT:        sc_out = {{(W-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_DIV: begin  // only reached with in2 == 0
        sc_out  = '1;
        sc_hi   = in1;
        sc_div0 = 1'b1;
      end
      default:       sc_out = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    div_sh  = {hi_q, lo_q[W-1]};
    div_ge  = (div_sh >= {1'b0, a_q});
    if (is_mul_q) begin
      it_hi = mul_sum[W:1];
      it_lo = {mul_sum[0], lo_q[W-1:1]};
    end else begin
      // Partial remainder is below 2*divisor, so the difference fits in W bits.
      it_hi = div_ge ? (div_sh[W-1:0] - a_q) : div_sh[W-1:0];
      it_lo = {lo_q[W-2:0], div_ge};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    zero_d   = zero_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL || (op == OP_DIV && in2 != '0)) begin
            state_d  = S_ITER;
            cnt_d    = SHW'(W-1);
            is_mul_d = (op == OP_MUL);
            a_d      = in2;
            hi_d     = '0;
            lo_d     = in1;
          end else begin
            done_d   = 1'b1;
            out_d    = sc_out;
            out_hi_d = sc_hi;
            zero_d   = (sc_out == '0);
            div0_d   = sc_div0;
          end
        end
      end
      S_ITER: begin
        hi_d = it_hi;
        lo_d = it_lo;
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          out_d    = it_lo;
          out_hi_d = it_hi;
          zero_d   = (it_lo == '0);
          div0_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b1;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      zero_q   <= zero_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == S_ITER);
  assign done   = done_q;
  assign out    = out_q;
  assign out_hi = out_hi_q;
  assign zero   = zero_q;
  assign div0   = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] in1, in2;
  logic         busy, done, zero, div0;
  logic [W-1:0] out, out_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;
  int busy_cnt;

  alu_seq #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .out_hi (out_hi),
    .zero   (zero),
    .div0   (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
  endtask

  // After an accepted iterative op: count edges until done (bounded) and
  // samples with busy high, counting the accept-edge sample as well.
  task automatic wait_done(input bit scramble, output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (scramble) issue(4'b0010, $urandom, $urandom);
      else          start = 1'b0;
      if (scramble) start = i[0];
      tick();
      n_edges++;
      if (done) break;
      if (busy) n_busy++;
    end
  endtask

  logic [3:0]   v_op   [9];
  logic [W-1:0] v_in1  [9];
  logic [W-1:0] v_in2  [9];
  logic [W-1:0] v_out  [9];
  logic         v_zero [9];

  initial begin
    v_op   = '{4'b0010, 4'b0110, 4'b0100, 4'b0111, 4'b1011, 4'b1000, 4'b1111, 4'b0101, 4'b1001};
    v_in1  = '{32'hFFFFFFFF, 32'd5, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd5, 32'd123, 32'h0000F0F0, 32'h0000F0F0};
    v_in2  = '{32'd1, 32'd7, 32'd35, 32'd0, 32'd1, 32'd5, 32'd456, 32'h0000FF00, 32'h00000F0F};
    v_out  = '{32'd0, 32'hFFFFFFFE, 32'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h0000F000, 32'h0000FFFF};
    v_zero = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 4'b0000;
    in1   = '0;
    in2   = '0;
    #12;
    chk("reset busy",   W'(busy),  '0);
    chk("reset done",   W'(done),  '0);
    chk("reset out",    out,       '0);
    chk("reset out_hi", out_hi,    '0);
    chk("reset zero",   W'(zero),  W'(1));
    chk("reset div0",   W'(div0),  '0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a MUL
    issue(4'b1100, 32'd7, 32'd9);
    tick();
    chk("mul accept busy", W'(busy), W'(1));
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", W'(busy), '0);
    chk("midrst done", W'(done), '0);
    chk("midrst out",  out,      '0);
    chk("midrst zero", W'(zero), W'(1));
    #1;
    rst_n = 1'b1;
    tick();
    issue(4'b0010, 32'd3, 32'd4);
    tick();
    chk("post-rst add done", W'(done), W'(1));
    chk("post-rst add out",  out,      32'd7);
    chk("post-rst add busy", W'(busy), '0);

    // Single-cycle sweep with a start every cycle
    for (int i = 0; i < 9; i++) begin
      issue(v_op[i], v_in1[i], v_in2[i]);
      tick();
      chk($sformatf("sweep%0d done", i),   W'(done),   W'(1));
      chk($sformatf("sweep%0d out", i),    out,        v_out[i]);
      chk($sformatf("sweep%0d zero", i),   W'(zero),   W'(v_zero[i]));
      chk($sformatf("sweep%0d out_hi", i), out_hi,     '0);
    end
    start = 1'b0;
    tick();
    chk("sweep idle done", W'(done), '0);
    chk("sweep hold out",  out,      32'h0000FFFF);

    // Full-range MUL
    issue(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    chk("mul busy at accept", W'(busy), W'(1));
    chk("mul done at accept", W'(done), '0);
    wait_done(1'b0, edges, busy_cnt);
    chk("mul latency",   W'(edges),    W'(32));
    chk("mul busy span", W'(busy_cnt), W'(32));
    chk("mul out_hi",    out_hi,       32'hFFFFFFFE);
    chk("mul out",       out,          32'h00000001);
    chk("mul busy end",  W'(busy),     '0);
    chk("mul zero",      W'(zero),     '0);
    tick();
    chk("mul done pulse", W'(done), '0);

    // DIV by zero completes in one cycle; next completion clears div0
    issue(4'b1101, 32'd100, 32'd0);
    tick();
    chk("div0 done",   W'(done), W'(1));
    chk("div0 busy",   W'(busy), '0);
    chk("div0 out",    out,      32'hFFFFFFFF);
    chk("div0 out_hi", out_hi,   32'd100);
    chk("div0 flag",   W'(div0), W'(1));
    start = 1'b0;
    tick();
    chk("div0 hold flag", W'(div0), W'(1));

    // DIV 100 / 7
    issue(4'b1101, 32'd100, 32'd7);
    tick();
    chk("div busy at accept", W'(busy), W'(1));
    wait_done(1'b0, edges, busy_cnt);
    chk("div latency", W'(edges), W'(32));
    chk("div out",     out,       32'd14);
    chk("div out_hi",  out_hi,    32'd2);
    chk("div div0",    W'(div0),  '0);

    // DIV 200 / 9 with start/operands scrambled while busy
    issue(4'b1101, 32'd200, 32'd9);
    tick();
    wait_done(1'b1, edges, busy_cnt);
    chk("prot latency", W'(edges), W'(32));
    chk("prot out",     out,       32'd22);
    chk("prot out_hi",  out_hi,    32'd2);
    chk("prot zero",    W'(zero),  '0);
    issue(4'b0010, 32'd10, 32'd20);
    tick();
    chk("done-cycle add done",   W'(done), W'(1));
    chk("done-cycle add out",    out,      32'd30);
    chk("done-cycle add out_hi", out_hi,   '0);
    chk("done-cycle add busy",   W'(busy), '0);
    start = 1'b0;
    tick();
    chk("final done low", W'(done), '0);
    chk("final hold out", out,      32'd30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
